mem_port_arbiter: RTL

Sequential arbiter sharing the single-ported instruction/data SRAM between the fetch stage and the memory stage of the ARM pipeline. Grants one multi-cycle access at a time, inserts a fixed number of wait states, returns registered read data, and produces the freeze signals that stall fetch or the whole pipeline while an access is outstanding. Sits between the IF/MEM stages and the SRAM model; `freeze_if` drives the IF stage freeze input, `freeze_pipe` drives the pipeline-wide stall.

---
 rtl/mem_port_arbiter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-ported SRAM between fetch and memory stages,
//               with fixed wait states, registered read data and pipeline
//               freeze outputs. Optional fetch starvation guard is enabled by
//               defining ARB_STARVE_GUARD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int WAIT_STATES  = 2,
    parameter int ADDR_W       = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    input  logic              flush,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    input  logic              mem_rd_en,
    input  logic              mem_wr_en,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_ready,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata,
    output logic              freeze_if,
    output logic              freeze_pipe
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FETCH = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;

    localparam int                 c_CNT_W    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WAIT_STATES);

    logic [1:0]        r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic              r_drop;
    logic              r_sram_en;
    logic              r_sram_we;
    logic [ADDR_W-1:0] r_sram_addr;
    logic [31:0]       r_sram_wdata;
    logic [31:0]       r_if_rdata;
    logic [31:0]       r_mem_rdata;
    logic              r_if_ready;
    logic              r_mem_ready;

    logic w_idle;
    logic w_last;
    logic w_data_req;
    logic w_fetch_req;
    logic w_starved;
    logic w_grant_data;
    logic w_grant_fetch;

    // A requester whose ready pulse is high is still holding its request
    // line; it must not be seen as a fresh request in that cycle.
    assign w_data_req  = (mem_rd_en | mem_wr_en) & ~r_mem_ready;
    assign w_fetch_req = if_req & ~r_if_ready;
    assign w_idle      = (r_state == c_ST_IDLE);
    assign w_last      = (r_cnt == c_CNT_LAST);

    assign w_grant_data  = w_idle & w_data_req & ~(w_starved & w_fetch_req);
    assign w_grant_fetch = w_idle & w_fetch_req & ~w_grant_data;

`ifdef ARB_STARVE_GUARD_EN
    localparam int c_STV_W = $clog2(STARVE_LIMIT + 1);

    logic [c_STV_W-1:0] r_starve;

    assign w_starved = (r_starve >= c_STV_W'(STARVE_LIMIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= '0;
        end else if (!if_req || w_grant_fetch) begin
            r_starve <= '0;
        end else if (w_grant_data && !w_starved) begin
            r_starve <= r_starve + c_STV_W'(1);
        end
    end
`else
    assign w_starved = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_cnt        <= '0;
            r_drop       <= 1'b0;
            r_sram_en    <= 1'b0;
            r_sram_we    <= 1'b0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
            r_if_rdata   <= '0;
            r_mem_rdata  <= '0;
            r_if_ready   <= 1'b0;
            r_mem_ready  <= 1'b0;
        end else begin
            r_if_ready  <= 1'b0;
            r_mem_ready <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_grant_data) begin
                        r_state      <= c_ST_DATA;
                        r_cnt        <= '0;
                        r_sram_en    <= 1'b1;
                        r_sram_we    <= mem_wr_en;
                        r_sram_addr  <= mem_addr[ADDR_W+1:2];
                        r_sram_wdata <= mem_wdata;
                    end else if (w_grant_fetch) begin
                        r_state     <= c_ST_FETCH;
                        r_cnt       <= '0;
                        r_drop      <= 1'b0;
                        r_sram_en   <= 1'b1;
                        r_sram_we   <= 1'b0;
                        r_sram_addr <= if_addr[ADDR_W+1:2];
                    end
                end
                c_ST_FETCH: begin
                    // A flushed fetch still runs to completion; the SRAM cannot abort.
                    if (w_last) begin
                        r_state   <= c_ST_IDLE;
                        r_sram_en <= 1'b0;
                        r_sram_we <= 1'b0;
                        r_drop    <= 1'b0;
                        if (!(r_drop || flush)) begin
                            r_if_rdata <= sram_rdata;
                            r_if_ready <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                        if (flush) begin
                            r_drop <= 1'b1;
                        end
                    end
                end
                c_ST_DATA: begin
                    if (w_last) begin
                        r_state     <= c_ST_IDLE;
                        r_sram_en   <= 1'b0;
                        r_sram_we   <= 1'b0;
                        r_mem_ready <= 1'b1;
                        if (!r_sram_we) begin
                            r_mem_rdata <= sram_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: begin
                    r_state   <= c_ST_IDLE;
                    r_sram_en <= 1'b0;
                    r_sram_we <= 1'b0;
                end
            endcase
        end
    end

    assign if_rdata    = r_if_rdata;
    assign if_ready    = r_if_ready;
    assign mem_rdata   = r_mem_rdata;
    assign mem_ready   = r_mem_ready;
    assign sram_en     = r_sram_en;
    assign sram_we     = r_sram_we;
    assign sram_addr   = r_sram_addr;
    assign sram_wdata  = r_sram_wdata;
    assign freeze_if   = if_req & ~r_if_ready;
    assign freeze_pipe = (mem_rd_en | mem_wr_en) & ~r_mem_ready;

    // Byte-offset and high address bits are intentionally ignored.
    logic w_unused;
    assign w_unused = &{1'b0, if_addr[31:ADDR_W+2], if_addr[1:0],
                        mem_addr[31:ADDR_W+2], mem_addr[1:0]};

endmodule

`default_nettype wire
